// File: rtl/fns_dec_seq.sv
// fns_dec_seq -- sequential Fibonacci-number-system (FNS) decoder.
//
// A masked codeword (codein & en_flag) is accepted in IDLE, then walked one
// bit per RUN cycle, LSB first. Bit i carries weight F(i), where
// F(0)=F(1)=1 and F(i)=F(i-1)+F(i-2). The weights are produced on the fly
// by two weight registers. The result is presented in DONE under a
// valid/ready handshake.
//
// Parameters
//   CODE_W    codeword width (3..32)
//   DATA_W    decoded output width (2..32)
//   CHECK_ADJ 1: flag adjacent ones in the masked code, 0: err tied low
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   in_valid  codein/en_flag valid
//   in_ready  block accepts a codeword (IDLE only)
//   codein    FNS codeword
//   en_flag   per-bit enable mask
//   out_valid dataout/ovf/err valid (DONE only)
//   out_ready consumer accepts the result
//   dataout   decoded value modulo 2^DATA_W
//   ovf       exact sum >= 2^DATA_W
//   err       masked codeword has two adjacent ones
module fns_dec_seq #(
  parameter int CODE_W    = 9,
  parameter int DATA_W    = 7,
  parameter int CHECK_ADJ = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] codein,
  input  logic [CODE_W-1:0] en_flag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] dataout,
  output logic              ovf,
  output logic              err
);

  // The "next" weight register reaches F(n+1) after the last RUN cycle.
  // Size both weight registers for that value so no weight is ever truncated.
  function automatic int fib_bits(input int n);
    longint a;
    longint b;
    longint t;
    a = 64'd1;
    b = 64'd1;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return $clog2(b + 64'd1);
  endfunction

  localparam int WT_W  = fib_bits(CODE_W);
  localparam int SUM_W = ((WT_W > DATA_W) ? WT_W : DATA_W) + 1;
  localparam int CNT_W = $clog2(CODE_W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_accept;
  logic               w_step;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [CODE_W-1:0]  r_sh;
  logic [DATA_W:0]    r_acc;
  logic [WT_W-1:0]    r_wt_cur;
  logic [WT_W-1:0]    r_wt_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_prev;
  logic               r_ovf;
  logic               r_err;
  logic [SUM_W-1:0]   w_sum;

  // Exact sum of the accumulator and the current weight. Any bit at or
  // above DATA_W means the true value has left the DATA_W-bit range.
  assign w_sum = SUM_W'(r_acc) + SUM_W'(r_wt_cur);

  // State register; in_ready/out_valid are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_DONE);
    end
  end

  // Next-state decode and datapath strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (r_cnt == CNT_W'(CODE_W - 1)) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE: begin
        // Leaving DONE lands in IDLE; acceptance can only happen from IDLE,
        // so a codeword is never taken on the same edge as the result.
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: capture on accept, one bit per RUN cycle, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh     <= '0;
      r_acc    <= '0;
      r_wt_cur <= WT_W'(1);
      r_wt_nxt <= WT_W'(1);
      r_cnt    <= '0;
      r_prev   <= 1'b0;
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      r_sh     <= codein & en_flag;
      r_acc    <= '0;
      r_wt_cur <= WT_W'(1);
      r_wt_nxt <= WT_W'(1);
      r_cnt    <= '0;
      r_prev   <= 1'b0;
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
    end else if (w_step) begin
      if (r_sh[0]) begin
        r_acc <= w_sum[DATA_W:0];
        if (w_sum[SUM_W-1:DATA_W] != '0) begin
          r_ovf <= 1'b1;
        end
      end
      if ((CHECK_ADJ != 0) && r_sh[0] && r_prev) begin
        r_err <= 1'b1;
      end
      r_prev   <= r_sh[0];
      r_sh     <= {1'b0, r_sh[CODE_W-1:1]};
      r_wt_cur <= r_wt_nxt;
      r_wt_nxt <= r_wt_cur + r_wt_nxt;
      r_cnt    <= r_cnt + CNT_W'(1);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign dataout   = r_acc[DATA_W-1:0];
  assign ovf       = r_ovf;
  assign err       = (CHECK_ADJ != 0) ? r_err : 1'b0;

endmodule

// File: doc/fns_dec_seq.md
FNS_DEC_SEQ -- requirements
Module: fns_dec_seq

Interface
REQ-001 The block SHALL provide parameter CODE_W, default 9: codeword width in bits (legal range 3..32).
REQ-002 The block SHALL provide parameter DATA_W, default 7: binary output width in bits (legal range 2..32).
REQ-003 The block SHALL provide parameter CHECK_ADJ, default 1: when 1, adjacent-ones checking is enabled; when 0, err is tied to 0.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port in_valid, input, 1 bit: codein and en_flag are valid.
REQ-007 Port in_ready, output, 1 bit: the block accepts a codeword.
REQ-008 Port codein, input, CODE_W bits: FNS codeword; bit i carries Fibonacci weight F(i).
REQ-009 Port en_flag, input, CODE_W bits: per-bit enable mask; a bit with en_flag=0 contributes nothing.
REQ-010 Port out_valid, output, 1 bit: dataout, ovf and err are valid.
REQ-011 Port out_ready, input, 1 bit: the consumer accepts the result.
REQ-012 Port dataout, output, DATA_W bits: decoded binary value, modulo 2^DATA_W.
REQ-013 Port ovf, output, 1 bit: the exact sum is >= 2^DATA_W.
REQ-014 Port err, output, 1 bit: the masked codeword contains two adjacent ones.

Function
REQ-015 Weights SHALL be F(0)=1, F(1)=1 and F(i)=F(i-1)+F(i-2), generated internally by two weight registers; no external weight inputs.
REQ-016 Weight registers SHALL be wide enough to hold F(CODE_W-1) exactly; no truncation of weights.
REQ-017 Masked code SHALL be codein AND en_flag, captured at acceptance.
REQ-018 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-019 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-020 IDLE with in_valid=1: the block SHALL capture the masked code into the shift register, clear acc, ovf and err, set both weight registers to 1, clear the bit counter, and go to RUN.
REQ-021 Each RUN cycle: the block SHALL add the current weight to acc if shift-register bit 0 is 1, shift right by 1, advance the weights (cur<=next, next<=cur+next) and increment the counter.
REQ-022 RUN SHALL last exactly CODE_W cycles; out_valid SHALL rise CODE_W rising edges after the accepting edge.
REQ-023 acc SHALL hold at least DATA_W+1 bits; ovf SHALL be set sticky when any addition carries out of DATA_W bits or the added weight is >= 2^DATA_W.
REQ-024 dataout SHALL equal the low DATA_W bits of the exact sum.
REQ-025 With CHECK_ADJ=1, err SHALL be set sticky when the current shift bit 0 and the previous processed bit are both 1.
REQ-026 In DONE, dataout, ovf and err SHALL stay stable while out_ready=0, for any number of cycles.
REQ-027 DONE with out_ready=1 SHALL go to IDLE; no new codeword SHALL be accepted on that same edge.
REQ-028 in_valid SHALL be ignored outside IDLE; codein and en_flag changes during RUN SHALL have no effect.
REQ-029 CODE_W=3 and all-zero masked codes SHALL produce dataout=0, ovf=0 and err=0 with the same latency.

Reset
REQ-030 When rst=1 at a rising edge, the block SHALL go to IDLE and clear acc, the shift register, the counter, dataout, ovf and err; both weight registers SHALL reset to 1.
REQ-031 After reset, in_ready SHALL be 1 and out_valid SHALL be 0 from the first edge with rst=1; reset SHALL have priority over all other inputs.
REQ-032 Reset in RUN or DONE SHALL discard the in-flight codeword; no out_valid pulse SHALL follow for it.

Verification
REQ-033 Defaults, codein=9'h1FF, en_flag=9'h1FF, out_ready=1 -> out_valid 9 edges after acceptance; dataout=88, ovf=0, err=1.
REQ-034 Defaults, codein=9'b101010101, en_flag=9'h1FF -> dataout=55, err=0, ovf=0; codein=9'h1FF with en_flag=9'h100 -> dataout=34, err=0.
REQ-035 DATA_W=6, codein=9'h1FF, en_flag=9'h1FF -> dataout=24, ovf=1.
REQ-036 Backpressure: out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0 throughout; out_ready=1 -> IDLE on the next edge, in_ready=1.
REQ-037 rst=1 at RUN cycle 4 -> next edge: IDLE, in_ready=1, out_valid=0; a new codeword 9'b000000011 then gives dataout=2, err=1.
REQ-038 CHECK_ADJ=0, codein=9'h1FF -> err=0 and dataout=88.
